// File: rtl/and_unit_arbiter.sv
// Round-robin arbiter that shares one registered bitwise-AND unit among N_REQ requesters.
// Flow: IDLE (grant and latch operands) -> BUSY (compute) -> DONE (hold the result until ready).
module and_unit_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int ID_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] a_in,
  input  logic [N_REQ*DATA_W-1:0] b_in,
  output logic [N_REQ-1:0]        grant,
  output logic [DATA_W-1:0]       result,
  output logic [ID_W-1:0]         result_id,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     w_ptr_nxt;
  logic [ID_W-1:0]     w_winner;
  logic                w_found;
  logic                w_accept;
  logic [N_REQ-1:0]    w_winner_oh;
  logic [DATA_W-1:0]   w_a_sel;
  logic [DATA_W-1:0]   w_b_sel;
  logic [DATA_W-1:0]   r_a_lat;
  logic [DATA_W-1:0]   r_b_lat;
  logic [N_REQ-1:0]    r_grant;
  logic [DATA_W-1:0]   r_result;
  logic [ID_W-1:0]     r_result_id;
  logic                r_result_valid;
  logic                r_busy;

  // The first pass covers indices from the pointer upward; the second pass
  // covers the indices below the pointer, which gives the modulo wrap.
  // NOTE: every signal written here gets a default first. Otherwise a path
  // that leaves a signal unassigned would infer a latch.
  always_comb begin
    w_found     = 1'b0;
    w_winner    = '0;
    w_winner_oh = '0;
    w_a_sel     = '0;
    w_b_sel     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && req[i] && (i >= int'(r_ptr))) begin
        w_found        = 1'b1;
        w_winner       = ID_W'(i);
        w_winner_oh[i] = 1'b1;
        w_a_sel        = a_in[i*DATA_W +: DATA_W];
        w_b_sel        = b_in[i*DATA_W +: DATA_W];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && req[i] && (i < int'(r_ptr))) begin
        w_found        = 1'b1;
        w_winner       = ID_W'(i);
        w_winner_oh[i] = 1'b1;
        w_a_sel        = a_in[i*DATA_W +: DATA_W];
        w_b_sel        = b_in[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_accept  = (r_state == S_IDLE) && w_found;
  assign w_ptr_nxt = (w_winner == ID_W'(N_REQ - 1)) ? '0 : w_winner + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_BUSY;
      S_BUSY:  w_state_nxt = S_DONE;
      S_DONE:  if (result_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments. All flops then
  // update together from values sampled before the edge, with no ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: the operand latches are plain registers, not a memory. Resetting
  // them is cheap, and it keeps the state after reset deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr          <= '0;
      r_a_lat        <= '0;
      r_b_lat        <= '0;
      r_grant        <= '0;
      r_result       <= '0;
      r_result_id    <= '0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_grant <= w_accept ? w_winner_oh : '0;
      if (w_accept) begin
        r_a_lat     <= w_a_sel;
        r_b_lat     <= w_b_sel;
        r_result_id <= w_winner;
        r_ptr       <= w_ptr_nxt;
      end
      if (r_state == S_BUSY) r_result <= r_a_lat & r_b_lat;
      // Flags are registered from the next state so that they line up with r_state.
      r_result_valid <= (w_state_nxt == S_DONE);
      r_busy         <= (w_state_nxt != S_IDLE);
    end
  end

  assign grant        = r_grant;
  assign result       = r_result;
  assign result_id    = r_result_id;
  assign result_valid = r_result_valid;
  assign busy         = r_busy;

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Directed bench for and_unit_arbiter: a table of single operations plus hand-written
// sequences for contention, backpressure, reset during an operation and a withdrawn request.
module tb_and_unit_arbiter;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 8;
  localparam int ID_W   = 2;
  localparam logic [7:0] A_BG = 8'hE7;
  localparam logic [7:0] B_BG = 8'h7E;

  logic                    clk;
  logic                    rst_n;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] a_in;
  logic [N_REQ*DATA_W-1:0] b_in;
  logic [N_REQ-1:0]        grant;
  logic [DATA_W-1:0]       result;
  logic [ID_W-1:0]         result_id;
  logic                    result_valid;
  logic                    result_ready;
  logic                    busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] req;
    int         win;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] exp_grant;
    logic [1:0] exp_id;
    logic [7:0] exp_res;
  } vec_t;

  vec_t vecs[8];

  and_unit_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .a_in         (a_in),
    .b_in         (b_in),
    .grant        (grant),
    .result       (result),
    .result_id    (result_id),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Only slice `win` carries the operands; every other slice carries the background pattern.
  task automatic set_ops(input int win, input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < N_REQ; i++) begin
      a_in[i*DATA_W +: DATA_W] = (i == win) ? a : A_BG;
      b_in[i*DATA_W +: DATA_W] = (i == win) ? b : B_BG;
    end
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    req          = '0;
    result_ready = 1'b0;
    a_in         = '0;
    b_in         = '0;
    tick();
    tick();
    check("rst_grant", grant, 0);
    check("rst_result", result, 0);
    check("rst_result_id", result_id, 0);
    check("rst_valid", result_valid, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
  endtask

  function automatic int oh_to_idx(input logic [N_REQ-1:0] oh);
    for (int i = 0; i < N_REQ; i++) if (oh[i]) return i;
    return -1;
  endfunction

  // Runs one zero-wait operation: grant, then valid one edge later, then idle again.
  task automatic run_op(input vec_t v);
    int cyc;
    set_ops(v.win, v.a, v.b);
    req          = v.req;
    result_ready = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (grant == '0 && cyc < 8);
    check("op_grant", grant, v.exp_grant);
    check("op_grant_id", result_id, v.exp_id);
    check("op_busy_at_grant", busy, 1);
    check("op_valid_at_grant", result_valid, 0);
    req = '0;
    tick();
    check("op_valid", result_valid, 1);
    check("op_result", result, v.exp_res);
    check("op_result_id", result_id, v.exp_id);
    check("op_grant_cleared", grant, 0);
    tick();
    check("op_valid_one_cycle", result_valid, 0);
    check("op_idle", busy, 0);
  endtask

  initial begin
    int         g_idx[$];
    int         g_cyc[$];
    logic [7:0] res_q[$];
    logic       multi_hot;
    logic       saw2;
    logic       stray_valid;
    int         exp_seq[5];
    logic [7:0] exp_res_seq[5];
    vec_t       v;

    // The pointer carries over from one row to the next, starting at 0 after reset.
    vecs[0] = '{4'b0001, 0, 8'hF0, 8'h3C, 4'b0001, 2'd0, 8'h30};
    vecs[1] = '{4'b1001, 3, 8'hAA, 8'h0F, 4'b1000, 2'd3, 8'h0A};
    vecs[2] = '{4'b0001, 0, 8'h55, 8'hFF, 4'b0001, 2'd0, 8'h55};
    vecs[3] = '{4'b0110, 1, 8'hC3, 8'h3C, 4'b0010, 2'd1, 8'h00};
    vecs[4] = '{4'b0011, 0, 8'hFF, 8'h81, 4'b0001, 2'd0, 8'h81};
    vecs[5] = '{4'b1100, 2, 8'h9E, 8'hF3, 4'b0100, 2'd2, 8'h92};
    vecs[6] = '{4'b1111, 3, 8'hFF, 8'hFF, 4'b1000, 2'd3, 8'hFF};
    vecs[7] = '{4'b0110, 1, 8'h6C, 8'h3F, 4'b0010, 2'd1, 8'h2C};

    do_reset();
    for (int k = 0; k < 8; k++) run_op(vecs[k]);

    // Full contention: grants 0,1,2,3,0 three cycles apart.
    do_reset();
    result_ready = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      a_in[i*DATA_W +: DATA_W] = 8'hFF;
      b_in[i*DATA_W +: DATA_W] = 8'(i);
    end
    req       = 4'b1111;
    multi_hot = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (grant != '0) begin
        g_cyc.push_back(c);
        g_idx.push_back(oh_to_idx(grant));
      end
      if ($countones(grant) > 1) multi_hot = 1'b1;
      if (result_valid) res_q.push_back(result);
    end
    req = '0;
    exp_seq     = '{0, 1, 2, 3, 0};
    exp_res_seq = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h00};
    check("rr_grant_count", g_idx.size(), 5);
    check("rr_result_count", res_q.size(), 5);
    check("rr_multi_hot", multi_hot, 0);
    for (int k = 0; k < 5; k++) begin
      if (k < g_idx.size()) check("rr_grant_order", g_idx[k], exp_seq[k]);
      if (k < res_q.size()) check("rr_result", res_q[k], exp_res_seq[k]);
      if (k > 0 && k < g_cyc.size()) check("rr_spacing", g_cyc[k] - g_cyc[k-1], 3);
    end
    tick();
    tick();

    // Backpressure: the result holds for 5 stalled cycles; a new request waits until after the handshake.
    do_reset();
    set_ops(2, 8'h3C, 8'hFF);
    req = 4'b0100;
    tick();
    check("bp_grant", grant, 4'b0100);
    req = '0;
    tick();
    check("bp_valid", result_valid, 1);
    check("bp_result", result, 8'h3C);
    check("bp_result_id", result_id, 2);
    set_ops(0, 8'h81, 8'hFF);
    req = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_stall_valid", result_valid, 1);
      check("bp_stall_result", result, 8'h3C);
      check("bp_stall_id", result_id, 2);
      check("bp_stall_no_grant", grant, 0);
    end
    result_ready = 1'b1;
    tick();
    check("bp_handshake_valid", result_valid, 0);
    check("bp_handshake_no_grant", grant, 0);
    tick();
    check("bp_next_grant", grant, 4'b0001);
    req = '0;
    tick();
    check("bp_next_result", result, 8'h81);
    tick();

    // Reset in BUSY, between clock edges.
    do_reset();
    v = '{4'b0001, 0, 8'hFF, 8'hF0, 4'b0001, 2'd0, 8'hF0};
    run_op(v);
    set_ops(1, 8'h0F, 8'hFF);
    req = 4'b0010;
    tick();
    check("mr_grant", grant, 4'b0010);
    req = '0;
    #3;
    rst_n = 1'b0;
    #1;
    check("mr_grant_cleared", grant, 0);
    check("mr_valid_cleared", result_valid, 0);
    check("mr_busy_cleared", busy, 0);
    check("mr_result_cleared", result, 0);
    check("mr_id_cleared", result_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stray_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (result_valid) stray_valid = 1'b1;
    end
    check("mr_no_stray_result", stray_valid, 0);
    v = '{4'b0101, 0, 8'h3C, 8'h0F, 4'b0001, 2'd0, 8'h0C};
    run_op(v);
    v = '{4'b0100, 2, 8'hF0, 8'hAA, 4'b0100, 2'd2, 8'hA0};
    run_op(v);

    // A request pulsed only while the unit sits in DONE is never granted.
    do_reset();
    set_ops(0, 8'h77, 8'h0F);
    req = 4'b0001;
    tick();
    check("wd_grant", grant, 4'b0001);
    req = '0;
    tick();
    check("wd_valid", result_valid, 1);
    req  = 4'b0100;
    saw2 = 1'b0;
    tick();
    if (grant[2]) saw2 = 1'b1;
    req = '0;
    result_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (grant[2]) saw2 = 1'b1;
    end
    check("wd_no_grant2", saw2, 0);
    check("wd_result", result, 8'h07);
    check("wd_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
